grid_cursor_engine: RTL

Parametrised cursor and display generator for the UART MinOS virtual display. Keeps NUM_CURSORS cursors on a GRID_W x GRID_H cell grid and moves them on button events decoded from the MinOS `button_index`/`button_pressed` stream, with either clamp or wrap-around edge handling. Renders a registered one-byte-per-cell frame with cursor priority, blinking corner markers and a collision flag. Sits between the MinOS instance and the application top level, taking over that top level's hand-written counter, cursor and display logic.

---
 rtl/grid_cursor_engine.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/grid_cursor_engine.sv
// grid_cursor_engine: cursor movement, blink timer and registered frame
// renderer for the MinOS virtual display grid.
//
// Event strobe semantics: button_pressed is a single-cycle valid with no ready
// (the engine always accepts). Every cycle in which button_pressed=1 is one
// event carrying button_index. A strobe held high for N cycles is N events.
// Indices at or above 4*NUM_CURSORS are accepted and discarded.
module grid_cursor_engine #(
   parameter int GRID_W      = 8,
   parameter int GRID_H      = 8,
   parameter int NUM_CURSORS = 2,
   parameter int BLINK_TICKS = 100000000,
   parameter int WRAP        = 0,
   parameter logic [NUM_CURSORS*8-1:0] CURSOR_INIT  = {8'd14, 8'd9},
   parameter logic [NUM_CURSORS*8-1:0] CURSOR_COLOR = {8'h15, 8'h3F}
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         button_pressed,
   input  logic [7:0]                   button_index,
   output logic [GRID_W*GRID_H*8-1:0]   display,
   output logic [NUM_CURSORS*8-1:0]     cursor_pos,
   output logic [7:0]                   beat_count,
   output logic                         collision
);

   localparam int CELLS     = GRID_W * GRID_H;
   localparam int CORNER_TR = GRID_W - 1;
   localparam int CORNER_BL = (GRID_H - 1) * GRID_W;
   localparam int TICK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(BLINK_TICKS - 1);
   localparam logic [7:0]        W8          = 8'(GRID_W);
   localparam logic [7:0]        H8          = 8'(GRID_H);
   localparam logic [7:0]        EVENT_LIMIT = 8'(4 * NUM_CURSORS);

   // Event decode: index = 4*cursor + direction.
   logic       ev_valid;
   logic [5:0] ev_sel;
   logic [1:0] ev_dir;

   logic [NUM_CURSORS*8-1:0]   cursor_pos_next;
   logic [GRID_W*GRID_H*8-1:0] display_next;
   logic                       collision_next;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_last;
   logic              blink;

   assign ev_valid  = button_pressed && (button_index < EVENT_LIMIT);
   assign ev_sel    = button_index[7:2];
   assign ev_dir    = button_index[1:0];
   assign tick_last = (tick_cnt == TICK_LAST);

   // One step of a cursor in direction dir (0 left, 1 right, 2 up, 3 down).
   // At an edge the move is dropped (clamp) or lands on the opposite edge (wrap).
   function automatic logic [7:0] move_cell(input logic [7:0] pos,
                                            input logic [1:0] dir);
      logic [7:0] col;
      logic [7:0] row;
      col = pos % W8;
      row = pos / W8;
      case (dir)
         2'd0: begin
            if (col != 8'd0)       col = col - 8'd1;
            else if (WRAP != 0)    col = W8 - 8'd1;
         end
         2'd1: begin
            if (col != W8 - 8'd1)  col = col + 8'd1;
            else if (WRAP != 0)    col = 8'd0;
         end
         2'd2: begin
            if (row != 8'd0)       row = row - 8'd1;
            else if (WRAP != 0)    row = H8 - 8'd1;
         end
         default: begin
            if (row != H8 - 8'd1)  row = row + 8'd1;
            else if (WRAP != 0)    row = 8'd0;
         end
      endcase
      return row * W8 + col;
   endfunction

   // Next cursor positions: only the addressed cursor moves.
   always_comb begin
      cursor_pos_next = cursor_pos;
      for (int k = 0; k < NUM_CURSORS; k++) begin
         if (ev_valid && (ev_sel == 6'(k))) begin
            cursor_pos_next[8*k +: 8] = move_cell(cursor_pos[8*k +: 8], ev_dir);
         end
      end
   end

   // Cursor position register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cursor_pos <= CURSOR_INIT;
      end else begin
         cursor_pos <= cursor_pos_next;
      end
   end

   // Blink timer: on terminal count, wrap the tick counter, toggle blink, bump beat.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_cnt   <= '0;
         blink      <= 1'b0;
         beat_count <= 8'd0;
      end else if (tick_last) begin
         tick_cnt   <= '0;
         blink      <= ~blink;
         beat_count <= beat_count + 8'd1;
      end else begin
         tick_cnt   <= tick_cnt + TICK_W'(1);
      end
   end

   // Frame render from registered state: corner markers first, then cursors
   // from highest to lowest index so the lowest-numbered cursor wins a shared cell.
   always_comb begin
      display_next = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (blink) begin
            if (i == 0)              display_next[8*i +: 8] = 8'h30;
            else if (i == CORNER_TR) display_next[8*i +: 8] = 8'h0C;
            else if (i == CORNER_BL) display_next[8*i +: 8] = 8'h03;
         end
         for (int k = NUM_CURSORS - 1; k >= 0; k--) begin
            if (cursor_pos[8*k +: 8] == 8'(i)) begin
               display_next[8*i +: 8] = CURSOR_COLOR[8*k +: 8];
            end
         end
      end
   end

   // Collision: any pair of cursors on the same cell.
   always_comb begin
      collision_next = 1'b0;
      for (int j = 0; j < NUM_CURSORS; j++) begin
         for (int k = j + 1; k < NUM_CURSORS; k++) begin
            if (cursor_pos[8*j +: 8] == cursor_pos[8*k +: 8]) begin
               collision_next = 1'b1;
            end
         end
      end
   end

   // Output registers for frame and collision flag (one cycle behind cursor_pos).
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         display   <= '0;
         collision <= 1'b0;
      end else begin
         display   <= display_next;
         collision <= collision_next;
      end
   end

endmodule
